// File: rtl/lpif_ctrl_pkg.sv
// Shared constants and state encodings for the LPIF link bring-up controller.
package lpif_ctrl_pkg;

    localparam int CNT_W              = 16;
    localparam int MAX_RETRY_DEF      = 3;
    localparam int RETRAIN_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PHY_WAIT = 3'd1,
        ST_TX_ON    = 3'd2,
        ST_RX_ALIGN = 3'd3,
        ST_ACTIVE   = 3'd4,
        ST_RETRAIN  = 3'd5,
        ST_ERROR    = 3'd6
    } ctrl_state_e;

    // Plain-vector aliases so the FSM register stays a simple logic vector.
    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_PHY_WAIT = ST_PHY_WAIT;
    localparam logic [2:0] S_TX_ON    = ST_TX_ON;
    localparam logic [2:0] S_RX_ALIGN = ST_RX_ALIGN;
    localparam logic [2:0] S_ACTIVE   = ST_ACTIVE;
    localparam logic [2:0] S_RETRAIN  = ST_RETRAIN;
    localparam logic [2:0] S_ERROR    = ST_ERROR;

endpackage

// File: rtl/lpif_link_bringup_ctrl_if.sv
// Link-layer control/status bundle between the bring-up controller and its environment.
interface lpif_link_bringup_ctrl_if;
    import lpif_ctrl_pkg::*;

    logic             link_en;
    logic             phy_ready;
    logic             rx_lock;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] lock_timeout;
    logic             tx_online;
    logic             rx_online;
    logic             link_up;
    logic             link_err;
    logic [2:0]       ctrl_state;
    logic [1:0]       retry_cnt;

    modport master (
        input  link_en, phy_ready, rx_lock, settle_cycles, lock_timeout,
        output tx_online, rx_online, link_up, link_err, ctrl_state, retry_cnt
    );

    modport slave (
        output link_en, phy_ready, rx_lock, settle_cycles, lock_timeout,
        input  tx_online, rx_online, link_up, link_err, ctrl_state, retry_cnt
    );

endinterface

// File: rtl/lpif_ctrl_cnt.sv
// 16-bit clearable/loadable up-counter that stops at, and flags, its terminal value.
module lpif_ctrl_cnt
    import lpif_ctrl_pkg::*;
(
    input  logic             clk_wr,
    input  logic             rst_wr,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term_val,
    output logic             term_hit
);

    logic [CNT_W-1:0] count;

    assign term_hit = (count == term_val);

    always_ff @(posedge clk_wr) begin
        if (rst_wr || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !term_hit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lpif_link_bringup_ctrl.sv
// LPIF link bring-up sequencer: PHY settle, TX enable, RX alignment with retries, retrain.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | link disabled, all outputs low, retry count cleared
// PHY_WAIT | waiting for phy_ready to stay high for settle_cycles
// TX_ON    | tx_online for one cycle before alignment starts
// RX_ALIGN | tx/rx online, waiting for rx_lock within lock_timeout
// ACTIVE   | link up; loss of lock or PHY drops to RETRAIN
// RETRAIN  | tx/rx held offline for RETRAIN_CYCLES, then back to PHY_WAIT
// ERROR    | retries exhausted; only link_en low leaves
module lpif_link_bringup_ctrl
    import lpif_ctrl_pkg::*;
#(
    parameter int MAX_RETRY      = MAX_RETRY_DEF,
    parameter int RETRAIN_CYCLES = RETRAIN_CYCLES_DEF
) (
    input logic                       clk_wr,
    input logic                       rst_wr,
    lpif_link_bringup_ctrl_if.master  bus
);

    localparam logic [1:0]       RETRY_LIMIT  = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);
    localparam logic [CNT_W-1:0] RETRAIN_TERM = CNT_W'(RETRAIN_CYCLES - 1);

    logic [2:0]       state_q, state_nxt;
    logic [1:0]       retry_q, retry_nxt;
    logic             tx_q, rx_q, up_q, err_q;
    logic             settle_clr, settle_hit;
    logic             tmo_clr, tmo_inc, tmo_hit;
    logic [CNT_W-1:0] tmo_term;

    // Settle count restarts whenever phy_ready glitches low.
    assign settle_clr = (state_q != S_PHY_WAIT) || !bus.phy_ready;

    lpif_ctrl_cnt u_settle_cnt (
        .clk_wr   (clk_wr),
        .rst_wr   (rst_wr),
        .clr      (settle_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (1'b1),
        .term_val (bus.settle_cycles),
        .term_hit (settle_hit)
    );

    // One counter serves both the lock timeout and the retrain hold; it restarts on every state change.
    assign tmo_clr  = (state_nxt != state_q);
    assign tmo_inc  = (state_q == S_RX_ALIGN) || (state_q == S_RETRAIN);
    assign tmo_term = (state_q == S_RETRAIN) ? RETRAIN_TERM : bus.lock_timeout;

    lpif_ctrl_cnt u_tmo_cnt (
        .clk_wr   (clk_wr),
        .rst_wr   (rst_wr),
        .clr      (tmo_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (tmo_inc),
        .term_val (tmo_term),
        .term_hit (tmo_hit)
    );

    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        case (state_q)
            S_IDLE:     if (bus.link_en) state_nxt = S_PHY_WAIT;
            S_PHY_WAIT: if (bus.phy_ready && settle_hit) state_nxt = S_TX_ON;
            S_TX_ON:    state_nxt = S_RX_ALIGN;
            S_RX_ALIGN: begin
                if (bus.rx_lock) begin
                    state_nxt = S_ACTIVE;
                end else if (tmo_hit) begin
                    if (retry_q < RETRY_LIMIT) begin
                        state_nxt = S_RETRAIN;
                        retry_nxt = retry_q + 1'b1;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_ACTIVE:   if (!bus.rx_lock || !bus.phy_ready) state_nxt = S_RETRAIN;
            S_RETRAIN:  if (tmo_hit) state_nxt = S_PHY_WAIT;
            S_ERROR:    state_nxt = S_ERROR;
            default:    state_nxt = S_IDLE;
        endcase
        if (!bus.link_en) state_nxt = S_IDLE;
        if ((state_nxt == S_IDLE) || (state_nxt == S_ACTIVE)) retry_nxt = '0;
    end

    // Outputs are decoded from the next state so they line up with ctrl_state.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            up_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            retry_q <= retry_nxt;
            tx_q    <= (state_nxt == S_TX_ON) || (state_nxt == S_RX_ALIGN) || (state_nxt == S_ACTIVE);
            rx_q    <= (state_nxt == S_RX_ALIGN) || (state_nxt == S_ACTIVE);
            up_q    <= (state_nxt == S_ACTIVE);
            err_q   <= (state_nxt == S_ERROR);
        end
    end

    assign bus.ctrl_state = state_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.tx_online  = tx_q;
    assign bus.rx_online  = rx_q;
    assign bus.link_up    = up_q;
    assign bus.link_err   = err_q;

endmodule

// File: tb/tb_lpif_link_bringup_ctrl.sv
// Directed bench for the LPIF link bring-up controller.
module tb_lpif_link_bringup_ctrl;

    logic clk_wr = 1'b0;
    logic rst_wr;
    int   total  = 0;
    int   bad    = 0;

    lpif_link_bringup_ctrl_if bus ();

    lpif_link_bringup_ctrl #(
        .MAX_RETRY      (3),
        .RETRAIN_CYCLES (16)
    ) dut (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .bus    (bus)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_wr);
            #1;
        end
    endtask

    // Counts consecutive cycles spent in state s, bounded at 200.
    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while ((bus.ctrl_state == s) && (n < 200)) begin
            n++;
            tick(1);
        end
    endtask

    task automatic go_idle();
        bus.link_en = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst_wr            = 1'b1;
        bus.link_en       = 1'b1;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b0;
        bus.settle_cycles = 16'd4;
        bus.lock_timeout  = 16'd8;
        tick(3);
        total++;
        if (bus.ctrl_state !== 3'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", bus.ctrl_state);
        end
        total++;
        if ({bus.tx_online, bus.rx_online, bus.link_up, bus.link_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0000",
                            {bus.tx_online, bus.rx_online, bus.link_up, bus.link_err});
        end
        total++;
        if (bus.retry_cnt !== 2'd0) begin
            bad++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_cnt);
        end
        rst_wr = 1'b0;
        tick(1);
        total++;
        if (bus.ctrl_state !== 3'd1) begin
            bad++; $display("FAIL reset_release_phy_wait got=%0d exp=1", bus.ctrl_state);
        end
    endtask

    task automatic test_clean_bringup();
        int n;
        go_idle();
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err, bus.retry_cnt} !== 9'b0) begin
            bad++; $display("FAIL clean_idle got=%b exp=0",
                            {bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err, bus.retry_cnt});
        end
        bus.settle_cycles = 16'd4;
        bus.lock_timeout  = 16'd100;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b0;
        bus.link_en       = 1'b1;
        tick(1);
        count_state(3'd1, n);
        total++;
        if (n !== 5) begin
            bad++; $display("FAIL clean_phy_wait_cycles got=%0d exp=5", n);
        end
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online} !== {3'd2, 1'b1, 1'b0}) begin
            bad++; $display("FAIL clean_tx_on got=%b exp=01010", {bus.ctrl_state, bus.tx_online, bus.rx_online});
        end
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up} !== {3'd3, 3'b110}) begin
            bad++; $display("FAIL clean_rx_align got=%b exp=011110",
                            {bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up});
        end
        tick(9);
        total++;
        if (bus.ctrl_state !== 3'd3) begin
            bad++; $display("FAIL clean_still_aligning got=%0d exp=3", bus.ctrl_state);
        end
        bus.rx_lock = 1'b1;
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err} !== {3'd4, 4'b1110}) begin
            bad++; $display("FAIL clean_active got=%b exp=1001110",
                            {bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err});
        end
        total++;
        if (bus.retry_cnt !== 2'd0) begin
            bad++; $display("FAIL clean_retry got=%0d exp=0", bus.retry_cnt);
        end
    endtask

    task automatic test_glitch();
        int n;
        go_idle();
        total++;
        if (bus.ctrl_state !== 3'd0) begin
            bad++; $display("FAIL glitch_idle got=%0d exp=0", bus.ctrl_state);
        end
        bus.settle_cycles = 16'd4;
        bus.lock_timeout  = 16'd100;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b0;
        bus.link_en       = 1'b1;
        tick(1);
        tick(2);
        bus.phy_ready = 1'b0;
        tick(1);
        total++;
        if (bus.ctrl_state !== 3'd1) begin
            bad++; $display("FAIL glitch_still_waiting got=%0d exp=1", bus.ctrl_state);
        end
        bus.phy_ready = 1'b1;
        count_state(3'd1, n);
        total++;
        if (3 + n !== 8) begin
            bad++; $display("FAIL glitch_phy_wait_cycles got=%0d exp=8", 3 + n);
        end
        total++;
        if (bus.ctrl_state !== 3'd2) begin
            bad++; $display("FAIL glitch_tx_on got=%0d exp=2", bus.ctrl_state);
        end
    endtask

    task automatic test_timeout_exhaust();
        int n;
        go_idle();
        total++;
        if (bus.ctrl_state !== 3'd0) begin
            bad++; $display("FAIL exhaust_idle got=%0d exp=0", bus.ctrl_state);
        end
        bus.settle_cycles = 16'd0;
        bus.lock_timeout  = 16'd8;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b0;
        bus.link_en       = 1'b1;
        tick(1);
        count_state(3'd1, n);
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL zero_settle_phy_wait got=%0d exp=1", n);
        end
        count_state(3'd2, n);
        total++;
        if (n !== 1) begin
            bad++; $display("FAIL tx_on_one_cycle got=%0d exp=1", n);
        end
        for (int v = 1; v <= 3; v++) begin
            count_state(3'd3, n);
            total++;
            if (n !== 9) begin
                bad++; $display("FAIL align_timeout_cycles visit=%0d got=%0d exp=9", v, n);
            end
            total++;
            if ({bus.ctrl_state, bus.retry_cnt} !== {3'd5, 2'(v)}) begin
                bad++; $display("FAIL retrain_entry visit=%0d got state=%0d retry=%0d exp state=5 retry=%0d",
                                v, bus.ctrl_state, bus.retry_cnt, v);
            end
            total++;
            if ({bus.tx_online, bus.rx_online, bus.link_up} !== 3'b000) begin
                bad++; $display("FAIL retrain_outputs visit=%0d got=%b exp=000",
                                v, {bus.tx_online, bus.rx_online, bus.link_up});
            end
            count_state(3'd5, n);
            total++;
            if (n !== 16) begin
                bad++; $display("FAIL retrain_cycles visit=%0d got=%0d exp=16", v, n);
            end
            count_state(3'd1, n);
            count_state(3'd2, n);
        end
        count_state(3'd3, n);
        total++;
        if (n !== 9) begin
            bad++; $display("FAIL final_align_cycles got=%0d exp=9", n);
        end
        total++;
        if ({bus.ctrl_state, bus.link_err, bus.tx_online, bus.rx_online, bus.link_up} !== {3'd6, 4'b1000}) begin
            bad++; $display("FAIL error_entry got=%b exp=1101000",
                            {bus.ctrl_state, bus.link_err, bus.tx_online, bus.rx_online, bus.link_up});
        end
        tick(4);
        total++;
        if ({bus.ctrl_state, bus.link_err} !== {3'd6, 1'b1}) begin
            bad++; $display("FAIL error_sticky got state=%0d err=%b exp state=6 err=1", bus.ctrl_state, bus.link_err);
        end
        bus.link_en = 1'b0;
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.link_err, bus.retry_cnt} !== 6'b0) begin
            bad++; $display("FAIL error_exit got state=%0d err=%b retry=%0d exp 0/0/0",
                            bus.ctrl_state, bus.link_err, bus.retry_cnt);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        go_idle();
        bus.settle_cycles = 16'd2;
        bus.lock_timeout  = 16'd20;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b1;
        bus.link_en       = 1'b1;
        tick(1);
        count_state(3'd1, n);
        total++;
        if (n !== 3) begin
            bad++; $display("FAIL lock_loss_phy_wait got=%0d exp=3", n);
        end
        count_state(3'd2, n);
        count_state(3'd3, n);
        total++;
        if ({n[3:0], bus.ctrl_state} !== {4'd1, 3'd4}) begin
            bad++; $display("FAIL immediate_lock got cycles=%0d state=%0d exp cycles=1 state=4", n, bus.ctrl_state);
        end
        tick(3);
        bus.rx_lock = 1'b0;
        tick(1);
        bus.rx_lock = 1'b1;
        total++;
        if ({bus.ctrl_state, bus.retry_cnt, bus.link_up} !== {3'd5, 2'd0, 1'b0}) begin
            bad++; $display("FAIL lock_loss_retrain got state=%0d retry=%0d up=%b exp 5/0/0",
                            bus.ctrl_state, bus.retry_cnt, bus.link_up);
        end
        count_state(3'd5, n);
        total++;
        if (n !== 16) begin
            bad++; $display("FAIL lock_loss_retrain_cycles got=%0d exp=16", n);
        end
        count_state(3'd1, n);
        count_state(3'd2, n);
        count_state(3'd3, n);
        total++;
        if ({bus.ctrl_state, bus.link_up, bus.retry_cnt} !== {3'd4, 1'b1, 2'd0}) begin
            bad++; $display("FAIL relink got state=%0d up=%b retry=%0d exp 4/1/0",
                            bus.ctrl_state, bus.link_up, bus.retry_cnt);
        end
        bus.phy_ready = 1'b0;
        tick(1);
        bus.phy_ready = 1'b1;
        total++;
        if ({bus.ctrl_state, bus.retry_cnt} !== {3'd5, 2'd0}) begin
            bad++; $display("FAIL phy_drop_retrain got state=%0d retry=%0d exp 5/0", bus.ctrl_state, bus.retry_cnt);
        end
    endtask

    task automatic test_simultaneous();
        go_idle();
        bus.settle_cycles = 16'd0;
        bus.lock_timeout  = 16'd5;
        bus.phy_ready     = 1'b1;
        bus.rx_lock       = 1'b0;
        bus.link_en       = 1'b1;
        tick(3);
        tick(5);
        total++;
        if (bus.ctrl_state !== 3'd3) begin
            bad++; $display("FAIL simul_before_timeout got=%0d exp=3", bus.ctrl_state);
        end
        bus.rx_lock = 1'b1;
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.retry_cnt} !== {3'd4, 2'd0}) begin
            bad++; $display("FAIL simul_lock_wins got state=%0d retry=%0d exp 4/0", bus.ctrl_state, bus.retry_cnt);
        end
    endtask

    task automatic test_mid_reset();
        rst_wr = 1'b1;
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err, bus.retry_cnt} !== 9'b0) begin
            bad++; $display("FAIL mid_reset_outputs got=%b exp=0",
                            {bus.ctrl_state, bus.tx_online, bus.rx_online, bus.link_up, bus.link_err, bus.retry_cnt});
        end
        bus.rx_lock = 1'b0;
        rst_wr      = 1'b0;
        tick(1);
        total++;
        if (bus.ctrl_state !== 3'd1) begin
            bad++; $display("FAIL mid_reset_release got=%0d exp=1", bus.ctrl_state);
        end
        tick(2);
        total++;
        if (bus.ctrl_state !== 3'd3) begin
            bad++; $display("FAIL mid_reset_realign got=%0d exp=3", bus.ctrl_state);
        end
        bus.link_en = 1'b0;
        tick(1);
        total++;
        if ({bus.ctrl_state, bus.tx_online, bus.rx_online} !== 5'b0) begin
            bad++; $display("FAIL link_en_drop_align got=%b exp=00000", {bus.ctrl_state, bus.tx_online, bus.rx_online});
        end
    endtask

    initial begin
        test_reset();
        test_clean_bringup();
        test_glitch();
        test_timeout_exhaust();
        test_lock_loss();
        test_simultaneous();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpif_link_bringup_ctrl.md
LPIF_LINK_BRINGUP_CTRL -- requirements
Module: lpif_link_bringup_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 3: number of alignment retries before ERROR.
REQ-002 Parameter RETRAIN_CYCLES, default 16: cycles tx_online/rx_online are held low in RETRAIN.
REQ-003 Port clk_wr  in  1: single clock; all logic is on its rising edge.
REQ-004 Port rst_wr  in  1: reset, synchronous, active-high.
REQ-005 Port link_en  in  1: software request to bring the link up.
REQ-006 Port phy_ready  in  1: PHY lane ready.
REQ-007 Port rx_lock  in  1: receive marker/strobe alignment achieved.
REQ-008 Port settle_cycles  in  16: cycles phy_ready must stay high before TX is enabled.
REQ-009 Port lock_timeout  in  16: cycle budget in RX_ALIGN before a retry.
REQ-010 Port tx_online  out  1: drives the link-layer tx_online.
REQ-011 Port rx_online  out  1: drives the link-layer rx_online.
REQ-012 Port link_up  out  1: link is in ACTIVE.
REQ-013 Port link_err  out  1: retries exhausted.
REQ-014 Port ctrl_state  out  3: current state encoding.
REQ-015 Port retry_cnt  out  2: retries consumed in the current bring-up attempt.

Function
REQ-016 All outputs shall be registered.
REQ-017 States and encodings: IDLE=0, PHY_WAIT=1, TX_ON=2, RX_ALIGN=3, ACTIVE=4, RETRAIN=5, ERROR=6.
REQ-018 link_en low in any state shall force IDLE on the next cycle; this overrides every other transition.
REQ-019 IDLE: all outputs are 0; retry_cnt is cleared; link_en high moves to PHY_WAIT.
REQ-020 PHY_WAIT: a 16-bit counter increments while phy_ready is high and clears when phy_ready is low.
REQ-021 PHY_WAIT exit: when counter == settle_cycles and phy_ready is high, move to TX_ON; with settle_cycles=0 the exit occurs on the first cycle phy_ready is high.
REQ-022 TX_ON: tx_online=1 for exactly one cycle, then move to RX_ALIGN.
REQ-023 RX_ALIGN: tx_online=1 and rx_online=1; the timeout counter starts at 0 on entry.
REQ-024 RX_ALIGN with rx_lock high: move to ACTIVE.
REQ-025 RX_ALIGN with counter == lock_timeout and rx_lock low: if retry_cnt < MAX_RETRY, increment retry_cnt and move to RETRAIN; otherwise move to ERROR.
REQ-026 RX_ALIGN: rx_lock high takes priority over a timeout in the same cycle.
REQ-027 ACTIVE: link_up=1, tx_online=1, rx_online=1; retry_cnt is cleared on entry.
REQ-028 ACTIVE: rx_lock low or phy_ready low moves to RETRAIN without incrementing retry_cnt.
REQ-029 RETRAIN: tx_online=0, rx_online=0, link_up=0 for RETRAIN_CYCLES cycles, then move to PHY_WAIT.
REQ-030 ERROR: link_err=1 and all other outputs are 0; only link_en low exits, to IDLE.
REQ-031 retry_cnt saturates and never wraps.
REQ-032 Counters compare with equality and never wrap past their terminal value.

Reset
REQ-033 While rst_wr is high at a clock edge, the state becomes IDLE and all outputs and counters are 0.
REQ-034 Reset mid-operation, including in ACTIVE, shall drop tx_online/rx_online on the cycle following that edge.
REQ-035 After rst_wr falls with link_en high, PHY_WAIT shall be entered one cycle later.

Structure
REQ-036 The state enum, its encodings and the RETRAIN_CYCLES default shall live in the shared package lpif_ctrl_pkg.
REQ-037 One sub-module, lpif_ctrl_cnt, shall provide a 16-bit loadable/clearable counter with a terminal-match flag.
REQ-038 The counter sub-module shall be instanced for both the settle count and the timeout count.
REQ-039 Target size: 150-250 lines of RTL.

Verification
REQ-040 Clean bring-up: settle_cycles=4, phy_ready high, rx_lock rises 10 cycles into RX_ALIGN -> TX_ON after 5 PHY_WAIT cycles, then link_up=1, retry_cnt=0.
REQ-041 Glitch: phy_ready drops on PHY_WAIT cycle 3 with settle_cycles=4 -> counter restarts; TX_ON is delayed accordingly.
REQ-042 Timeout exhaustion: lock_timeout=8, rx_lock never high -> three RETRAIN visits of 16 cycles each with retry_cnt 1, 2, 3, then ERROR with link_err=1; link_en low -> IDLE.
REQ-043 Lock loss: in ACTIVE, rx_lock drops for 1 cycle -> RETRAIN, retry_cnt stays 0, link re-established.
REQ-044 Simultaneous events: rx_lock rises on the exact timeout cycle -> ACTIVE, not RETRAIN.
REQ-045 Mid-operation reset: rst_wr asserted in ACTIVE -> all outputs 0 the next cycle; link_en low in RX_ALIGN -> IDLE the next cycle.
